// File: rtl/dual_ram_scheduler_pkg.sv
// dual_ram_scheduler_pkg: shared widths, per-port latencies and types for the dual-port RAM scheduler.
package dual_ram_scheduler_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDRESS_WIDTH = 3;
  typedef enum logic {PORT_A, PORT_B} port_t;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  localparam int READ_LATENCY [2] = '{2, 3};
  localparam int WRITE_LATENCY [2] = '{3, 4};
  localparam int MAX_LAT = READ_LATENCY[1] > WRITE_LATENCY[1] ? READ_LATENCY[1] : WRITE_LATENCY[1];
  localparam int ORD_W = $clog2(MAX_LAT + 2);
endpackage

// File: rtl/dual_ram_port_tracker.sv
// dual_ram_port_tracker: issue register, busy window, in-flight address and read-return
// countdown for one RAM port.
module dual_ram_port_tracker #(
  parameter int DW = dual_ram_scheduler_pkg::DATA_WIDTH,
  parameter int AW = dual_ram_scheduler_pkg::ADDRESS_WIDTH,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          en_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          free_next_o,
  output logic          hazard_o,
  output logic          capture_o,
  output logic          pending_o
);
  localparam int LW = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
  logic [LW-1:0] busy_q, busy_d, rd_q, rd_d;
  logic          en_q, we_q, cap_q, in_flight;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  // busy_q counts the remaining busy cycles including the current one; a count of 1
  // means the window closes this cycle, so the port is free for the next issue.
  always_comb begin
    busy_d = issue_i ? (we_i ? LW'(WR_LAT) : LW'(RD_LAT)) : busy_q != '0 ? busy_q - 1'b1 : '0;
    rd_d = (issue_i && !we_i) ? LW'(RD_LAT) : rd_q != '0 ? rd_q - 1'b1 : '0;
    in_flight = busy_q > LW'(1);
    free_next_o = !in_flight;
    hazard_o = in_flight && addr_q == addr_i;
    pending_o = busy_q != '0 || rd_q != '0 || cap_q;
  end
  // cap_q is split from rd_q so a back-to-back read can reload the countdown in the
  // very cycle the previous read's data is being sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      rd_q <= '0;
      cap_q <= 1'b0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      rd_q <= rd_d;
      cap_q <= rd_q == LW'(1);
      en_q <= issue_i;
      if (issue_i) begin
        we_q <= we_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end
  assign en_o = en_q;
  assign we_o = we_q;
  assign addr_o = addr_q;
  assign wdata_o = wdata_q;
  assign capture_o = cap_q;
endmodule

// File: rtl/dual_ram_scheduler.sv
// dual_ram_scheduler: steers one valid/ready request stream onto RAM ports A/B, enforcing
// per-port latency, cross-port address hazards and in-order read responses.
module dual_ram_scheduler #(
  parameter int DATA_WIDTH = dual_ram_scheduler_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = dual_ram_scheduler_pkg::ADDRESS_WIDTH,
  parameter int RD_LAT_A = dual_ram_scheduler_pkg::READ_LATENCY[0],
  parameter int RD_LAT_B = dual_ram_scheduler_pkg::READ_LATENCY[1],
  parameter int WR_LAT_A = dual_ram_scheduler_pkg::WRITE_LATENCY[0],
  parameter int WR_LAT_B = dual_ram_scheduler_pkg::WRITE_LATENCY[1]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     a_en,
  output logic                     a_we,
  output logic [ADDRESS_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0]    a_wdata,
  input  logic [DATA_WIDTH-1:0]    a_rdata,
  output logic                     b_en,
  output logic                     b_we,
  output logic [ADDRESS_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]    b_wdata,
  input  logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     idle
);
  import dual_ram_scheduler_pkg::*;
  logic                  a_free, b_free, a_haz, b_haz, a_cap, b_cap, a_pend, b_pend;
  logic                  a_ok, b_ok, acc, a_iss, b_iss;
  port_t                 sel;
  state_t                state;
  logic [ORD_W-1:0]      yr_q, yr_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  // yr_q is the distance to the youngest outstanding read's sample cycle; a new read may
  // only take a port whose return lands strictly after it.
  always_comb begin
    a_ok = a_free && (req_we || ORD_W'(RD_LAT_A + 1) > yr_q);
    b_ok = b_free && (req_we || ORD_W'(RD_LAT_B + 1) > yr_q);
    sel = a_ok ? PORT_A : PORT_B;
    req_ready = rst_n && !a_haz && !b_haz && (a_ok || b_ok);
    acc = req_valid && req_ready;
    a_iss = acc && sel == PORT_A;
    b_iss = acc && sel == PORT_B;
    yr_d = (acc && !req_we) ? (a_iss ? ORD_W'(RD_LAT_A) : ORD_W'(RD_LAT_B))
         : yr_q != '0 ? yr_q - 1'b1 : '0;
    state = (a_pend || b_pend) ? ST_BUSY : ST_IDLE;
    idle = state == ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      yr_q <= yr_d;
      rsp_valid_q <= a_cap || b_cap;
      if (a_cap || b_cap) rsp_data_q <= a_cap ? a_rdata : b_rdata;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  dual_ram_port_tracker #(
    .DW(DATA_WIDTH), .AW(ADDRESS_WIDTH), .RD_LAT(RD_LAT_A), .WR_LAT(WR_LAT_A)
  ) u_trk_a (
    .clk(clk), .rst_n(rst_n), .issue_i(a_iss), .we_i(req_we), .addr_i(req_addr),
    .wdata_i(req_wdata), .en_o(a_en), .we_o(a_we), .addr_o(a_addr), .wdata_o(a_wdata),
    .free_next_o(a_free), .hazard_o(a_haz), .capture_o(a_cap), .pending_o(a_pend)
  );
  dual_ram_port_tracker #(
    .DW(DATA_WIDTH), .AW(ADDRESS_WIDTH), .RD_LAT(RD_LAT_B), .WR_LAT(WR_LAT_B)
  ) u_trk_b (
    .clk(clk), .rst_n(rst_n), .issue_i(b_iss), .we_i(req_we), .addr_i(req_addr),
    .wdata_i(req_wdata), .en_o(b_en), .we_o(b_we), .addr_o(b_addr), .wdata_o(b_wdata),
    .free_next_o(b_free), .hazard_o(b_haz), .capture_o(b_cap), .pending_o(b_pend)
  );
endmodule
